dm_cache_fsm: RTL and testbench
===============================

// Module: dm_cache_fsm
// PURPOSE
// Controller for the direct-mapped, write-back, write-allocate cache. Sequences the data array and tag array
// (dm_cache_tag) between CPU requests and the main-memory port. Also clears all tag valid bits after reset.
// Sits in dm_cache_top beside the two arrays. Both arrays are async-read, sync-write.
// PARAMETERS
// NUM_LINES  1024  lines swept in INIT; must equal array depth (2**10)
// PORTS
// clk        in   1         clock, all state on posedge
// rst        in   1         asynchronous, active-high reset
// cpu_req    in   cpu_req_type     {addr[31:0], data[31:0], rw(1=write), valid}; held stable until cpu_res.ready
// cpu_res    out  cpu_result_type  {data[31:0], ready}
// mem_req    out  mem_req_type     {addr[31:0], data[127:0], rw, valid}
// mem_data   in   mem_data_type    {data[127:0], ready}; ready = 1-cycle completion pulse
// tag_req    out  cache_index_type {index[9:0], we}
// tag_write  out  cache_tag_type   {valid, dirty, tag[17:0]}
// tag_read   in   cache_tag_type   async read of tag_req.index
// data_req   out  cache_index_type {index[9:0], we}
// data_write out  cache_data_type  128-bit line
// data_read  in   cache_data_type  async read of data_req.index
// BEHAVIOUR
// - Address split: tag = addr[31:14]; index = addr[13:4]; word = addr[3:2]; addr[1:0] ignored.
// - States: INIT, IDLE, COMPARE, WRITE_BACK, ALLOCATE; the state register and the 10-bit init counter
//   are the only flops.
// - All outputs are decoded combinationally from state, cpu_req, tag_read, data_read and mem_data.
// - rst (async): state=INIT, counter=0. During reset all we, mem_req.valid and cpu_res.ready are 0.
// - INIT: tag_req={counter,we=1}, tag_write=0, counter++. Lasts NUM_LINES cycles; last index 1023 -> IDLE.
//   cpu_req is ignored throughout INIT.
// - IDLE: cpu_req.valid -> COMPARE. No outputs are asserted.
// - COMPARE: tag_req.index = data_req.index = cpu index. hit = tag_read.valid && tag_read.tag==cpu tag.
//   - Read hit: cpu_res.data = data_read[32*word +: 32]; cpu_res.ready=1; -> IDLE.
//   - Write hit: data_req.we=1; data_write = data_read with word slot replaced by cpu_req.data.
//     Same cycle: tag_req.we=1 and tag_write={1,1,tag}; cpu_res.ready=1; -> IDLE.
//   - Miss with victim valid && dirty: -> WRITE_BACK.
//   - Any other miss: -> ALLOCATE.
//   - No tag write on a miss, so the victim tag remains readable in WRITE_BACK.
// - WRITE_BACK: mem_req={tag_read.tag,index,4'b0}, data=data_read, rw=1, valid=1.
//   Held until mem_data.ready; that cycle -> ALLOCATE.
// - ALLOCATE: mem_req={cpu tag,index,4'b0}, rw=0, valid=1.
//   On mem_data.ready: data_req.we=1, data_write=mem_data.data, tag_req.we=1, tag_write={1,0,cpu tag}; -> COMPARE.
//   The re-entered COMPARE then hits and completes normally; writes merge there.
// - Latency: hit = cpu_res.ready 1 cycle after IDLE samples valid.
//   Clean miss = 3 + memory wait; dirty miss = 4 + two memory waits.
// - cpu_res.ready is a single-cycle pulse. cpu_res.data is 0 whenever ready=0.
// - mem_data.ready outside WRITE_BACK/ALLOCATE is ignored.
// - Back-to-back memory transactions: the first ALLOCATE cycle after write-back completion is a new request.
// - cpu_req.valid may be asserted again in the IDLE cycle after ready; that request is accepted.
// - Reset mid-transaction: mem_req.valid drops immediately and the transaction is abandoned.
//   Dirty lines are lost; INIT re-sweeps all tags.
// STRUCTURE
// - Package cache_definition holds the interface types: cpu_req_type, cpu_result_type, mem_req_type,
//   mem_data_type, cache_tag_type, cache_index_type, cache_data_type.
// - It also holds the constants TAGMSB=31, TAGLSB=14.
// - Add the cache_state_e enum to cache_definition.
// - Sub-module: dm_cache_tag (tag array, 1024 x cache_tag_type), instantiated in dm_cache_top, not inside this FSM.
// - This block contains no storage arrays.
// TESTING
// 1. Reset release: no accepted request for 1024 cycles; then all tag_read.valid=0.
//    Read 0x0000_1000 misses -> mem_req rw=0 addr 0x0000_1000.
// 2. Fill: mem returns line 0x4444..._3333..._2222..._1111... Read 0x1004 -> data 0x2222_2222.
//    Repeat read -> ready 1 cycle after valid, no mem_req.
// 3. Write hit 0x1008 data 0xDEAD_BEEF -> tag dirty=1. Read 0x1008 -> 0xDEAD_BEEF; other words unchanged.
// 4. Conflict read 0x0004_1000, same index, dirty victim:
//    -> mem_req rw=1 addr 0x0000_1000 with merged line.
//    -> then rw=0 addr 0x0004_1000; no cpu_res.ready before refill.
// 5. Write miss 0x0008_2000 to a clean line: ALLOCATE, refill, merge.
//    -> tag {1,1,0x20}; mem_req never rw=1.
// 6. Assert rst during WRITE_BACK: mem_req.valid=0 same cycle. INIT re-runs 1024 cycles.
//    Stray mem_data.ready pulses are ignored.

Source files
------------

// File: rtl/cache_definition.sv
// Interface types and the controller state encoding shared by the direct-mapped cache blocks.
package cache_definition;

    localparam int TAGMSB  = 31;
    localparam int TAGLSB  = 14;
    localparam int INDEX_W = 10;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rw;
        logic        valid;
    } cpu_req_type;

    typedef struct packed {
        logic [31:0] data;
        logic        ready;
    } cpu_result_type;

    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
        logic         rw;
        logic         valid;
    } mem_req_type;

    typedef struct packed {
        logic [127:0] data;
        logic         ready;
    } mem_data_type;

    typedef struct packed {
        logic                     valid;
        logic                     dirty;
        logic [TAGMSB-TAGLSB:0]   tag;
    } cache_tag_type;

    typedef struct packed {
        logic [INDEX_W-1:0] index;
        logic               we;
    } cache_index_type;

    typedef logic [127:0] cache_data_type;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        COMPARE,
        WRITE_BACK,
        ALLOCATE
    } cache_state_e;

endpackage

// File: rtl/dm_cache_tag.sv
// Tag array: 1024 entries, asynchronous read, synchronous write. Contents are cleared by the
// controller's INIT sweep rather than by reset.
module dm_cache_tag
    import cache_definition::*;
(
    input  logic            clk,
    input  cache_index_type tag_req,
    input  cache_tag_type   tag_write,
    output cache_tag_type   tag_read
);

    cache_tag_type lines [0:(1<<INDEX_W)-1];

    always_ff @(posedge clk) begin
        if (tag_req.we) lines[tag_req.index] <= tag_write;
    end

    assign tag_read = lines[tag_req.index];

endmodule

// File: rtl/dm_cache_fsm.sv
// Write-back, write-allocate controller for the direct-mapped cache. Only the state and the
// INIT sweep counter are registered; every array/memory/CPU output is decoded from them.
module dm_cache_fsm
    import cache_definition::*;
#(
    parameter int NUM_LINES = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  cpu_req_type     cpu_req,
    output cpu_result_type  cpu_res,
    output mem_req_type     mem_req,
    input  mem_data_type    mem_data,
    output cache_index_type tag_req,
    output cache_tag_type   tag_write,
    input  cache_tag_type   tag_read,
    output cache_index_type data_req,
    output cache_data_type  data_write,
    input  cache_data_type  data_read
);

    localparam logic [INDEX_W-1:0] LAST = INDEX_W'(NUM_LINES - 1);

    cache_state_e           state;
    logic [INDEX_W-1:0]     cnt;

    logic [TAGMSB-TAGLSB:0] cpu_tag;
    logic [INDEX_W-1:0]     cpu_idx;
    logic [6:0]             word_lsb;
    logic                   hit;
    cache_data_type         merged;
    logic                   unused_addr_lsb;

    assign cpu_tag         = cpu_req.addr[TAGMSB:TAGLSB];
    assign cpu_idx         = cpu_req.addr[TAGLSB-1:4];
    assign word_lsb        = {cpu_req.addr[3:2], 5'b0};
    assign hit             = tag_read.valid && (tag_read.tag == cpu_tag);
    assign unused_addr_lsb = ^cpu_req.addr[1:0];

    always_comb begin
        merged                   = data_read;
        merged[word_lsb +: 32]   = cpu_req.data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            case (state)
                INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= IDLE;
                end
                IDLE:       if (cpu_req.valid) state <= COMPARE;
                COMPARE: begin
                    if (hit)                                 state <= IDLE;
                    else if (tag_read.valid && tag_read.dirty) state <= WRITE_BACK;
                    else                                     state <= ALLOCATE;
                end
                WRITE_BACK: if (mem_data.ready) state <= ALLOCATE;
                ALLOCATE:   if (mem_data.ready) state <= COMPARE;
                default:    state <= INIT;
            endcase
        end
    end

    always_comb begin
        cpu_res        = '0;
        mem_req        = '0;
        tag_req        = '0;
        tag_write      = '0;
        data_req       = '0;
        data_write     = '0;
        tag_req.index  = cpu_idx;
        data_req.index = cpu_idx;
        case (state)
            INIT: begin
                // The sweep's write enable is held off while reset is asserted.
                tag_req.index = cnt;
                tag_req.we    = !rst;
            end
            COMPARE: begin
                if (hit) begin
                    cpu_res.ready = 1'b1;
                    if (cpu_req.rw) begin
                        data_req.we   = 1'b1;
                        data_write    = merged;
                        tag_req.we    = 1'b1;
                        tag_write     = '{valid: 1'b1, dirty: 1'b1, tag: cpu_tag};
                    end else begin
                        cpu_res.data  = data_read[word_lsb +: 32];
                    end
                end
            end
            WRITE_BACK: begin
                // Victim address comes from the tag still sitting in the array.
                mem_req.addr  = {tag_read.tag, cpu_idx, 4'b0};
                mem_req.data  = data_read;
                mem_req.rw    = 1'b1;
                mem_req.valid = 1'b1;
            end
            ALLOCATE: begin
                mem_req.addr  = {cpu_tag, cpu_idx, 4'b0};
                mem_req.valid = 1'b1;
                if (mem_data.ready) begin
                    data_req.we = 1'b1;
                    data_write  = mem_data.data;
                    tag_req.we  = 1'b1;
                    tag_write   = '{valid: 1'b1, dirty: 1'b0, tag: cpu_tag};
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dm_cache_fsm.sv
// Bench for dm_cache_fsm with its tag and data arrays, a latency-randomised main memory and a
// line-level reference model of a write-back, write-allocate direct-mapped cache.
module tb_dm_cache_fsm;
    import cache_definition::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    cpu_req_type     cpu_req = '0;
    cpu_result_type  cpu_res;
    mem_req_type     mem_req;
    mem_data_type    mem_data = '0;
    cache_index_type tag_req, data_req;
    cache_tag_type   tag_write, tag_read;
    cache_data_type  data_write, data_read;

    always #5 clk = ~clk;

    dm_cache_fsm #(.NUM_LINES(1024)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_res(cpu_res),
        .mem_req(mem_req), .mem_data(mem_data),
        .tag_req(tag_req), .tag_write(tag_write), .tag_read(tag_read),
        .data_req(data_req), .data_write(data_write), .data_read(data_read)
    );

    dm_cache_tag u_tag (.clk(clk), .tag_req(tag_req), .tag_write(tag_write), .tag_read(tag_read));

    logic [127:0] darr [0:1023];
    always @(posedge clk) if (data_req.we) darr[data_req.index] <= data_write;
    assign data_read = darr[data_req.index];

    int nvec = 0, nerr = 0;

    // Reference model: which line each index holds, plus the coherent (gmem) and backing (bmem) views.
    bit           mv [1024];
    bit           md [1024];
    logic [17:0]  mt [1024];
    logic [127:0] bmem [logic [27:0]];
    logic [127:0] gmem [logic [27:0]];

    function automatic logic [127:0] init_line(logic [27:0] la);
        return {la, 4'hC, la, 4'h8, la, 4'h4, la, 4'h0} ^ {4{32'h5A00_0000}};
    endfunction
    function automatic logic [127:0] get_b(logic [27:0] la);
        if (bmem.exists(la)) return bmem[la];
        return init_line(la);
    endfunction
    function automatic logic [127:0] get_g(logic [27:0] la);
        if (gmem.exists(la)) return gmem[la];
        return init_line(la);
    endfunction

    bit           e_hit, e_wb;
    int           e_ntx;
    logic [31:0]  e_wb_addr, e_rd_addr, e_rdata;
    logic [127:0] e_wb_data;

    task automatic model(input logic [31:0] a, input logic [31:0] d, input bit rw);
        logic [27:0]  la  = a[31:4];
        logic [9:0]   idx = a[13:4];
        logic [17:0]  tg  = a[31:14];
        int           w   = int'(a[3:2]);
        logic [127:0] ln;
        e_hit     = mv[idx] && mt[idx] == tg;
        e_wb      = !e_hit && mv[idx] && md[idx];
        e_wb_addr = {mt[idx], idx, 4'h0};
        e_wb_data = get_g({mt[idx], idx});
        e_rd_addr = {tg, idx, 4'h0};
        e_ntx     = e_hit ? 0 : (e_wb ? 2 : 1);
        if (!e_hit) begin mv[idx] = 1; md[idx] = 0; mt[idx] = tg; end
        ln = get_g(la);
        if (rw) begin ln[w*32 +: 32] = d; gmem[la] = ln; md[idx] = 1; end
        e_rdata = ln[w*32 +: 32];
    endtask

    task automatic model_reset();
        foreach (mv[i]) begin mv[i] = 0; md[i] = 0; end
        gmem = bmem;
    endtask

    logic [31:0]  obs_rdata;
    int           obs_cyc, obs_lat, obs_bad0;
    bit           obs_to;
    logic [31:0]  tx_addr [$];
    bit           tx_rw   [$];
    logic [127:0] tx_data [$];

    // CPU driver plus main-memory responder; records what the controller did.
    task automatic access(input logic [31:0] a, input logic [31:0] d, input bit rw);
        bit act = 0;
        int wcnt = 0;
        bit got = 0;
        cpu_req.addr = a; cpu_req.data = d; cpu_req.rw = rw; cpu_req.valid = 1'b1;
        tx_addr.delete(); tx_rw.delete(); tx_data.delete();
        obs_cyc = 0; obs_lat = 0; obs_bad0 = 0; obs_rdata = 'x;
        for (int c = 0; c < 60 && !got; c++) begin
            @(posedge clk); #1 mem_data.ready = 1'b0; obs_cyc++;
            @(negedge clk);
            if (cpu_res.ready) begin
                got = 1; obs_rdata = cpu_res.data;
            end else begin
                if (cpu_res.data !== '0) obs_bad0++;
                if (mem_req.valid && !act) begin act = 1; wcnt = $urandom_range(0, 2); obs_lat += wcnt; end
                if (act) begin
                    if (wcnt == 0) begin
                        act = 0;
                        tx_addr.push_back(mem_req.addr); tx_rw.push_back(mem_req.rw); tx_data.push_back(mem_req.data);
                        if (mem_req.rw) bmem[mem_req.addr[31:4]] = mem_req.data;
                        else mem_data.data = get_b(mem_req.addr[31:4]);
                        mem_data.ready = 1'b1;
                    end else wcnt--;
                end
            end
        end
        obs_to = !got;
        @(posedge clk); #1 cpu_req.valid = 1'b0; mem_data.ready = 1'b0;
    endtask

    // Follows the INIT sweep from the current cycle until the first cycle without a tag write.
    task automatic run_init(output int nwe, output int nidx, output int nbad, input bit stray);
        nwe = 0; nidx = 0; nbad = 0;
        for (int c = 0; c < 1100; c++) begin
            #1;
            if (mem_req.valid || cpu_res.ready) nbad++;
            if (!tag_req.we) break;
            if (tag_req.index !== 10'(nwe) || tag_write !== '0) nidx++;
            nwe++;
            if (stray) mem_data.ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        mem_data.ready = 1'b0;
    endtask

    task automatic test_reset();
        int nwe, nidx, nbad, nvalid;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        nvec++; if ({tag_req.we, data_req.we, mem_req.valid, cpu_res.ready} !== 4'b0) begin
            nerr++; $display("FAIL reset_outputs got %b want 0000", {tag_req.we, data_req.we, mem_req.valid, cpu_res.ready}); end
        cpu_req = '{addr: 32'h0000_1000, data: 32'h0, rw: 1'b0, valid: 1'b1};
        @(negedge clk); rst = 1'b0;
        run_init(nwe, nidx, nbad, 1'b0);
        nvec++; if (nwe !== 1024) begin nerr++; $display("FAIL init_length got %0d want 1024", nwe); end
        nvec++; if (nidx !== 0) begin nerr++; $display("FAIL init_index got %0d bad want 0", nidx); end
        nvec++; if (nbad !== 0) begin nerr++; $display("FAIL init_quiet got %0d want 0", nbad); end
        nvalid = 0;
        for (int i = 0; i < 1024; i++) if (u_tag.lines[i].valid) nvalid++;
        nvec++; if (nvalid !== 0) begin nerr++; $display("FAIL init_tags_valid got %0d want 0", nvalid); end
        bmem[28'h100] = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        model_reset();
        model(32'h0000_1000, 32'h0, 1'b0);
        access(32'h0000_1000, 32'h0, 1'b0);
        nvec++; if (obs_to !== 0) begin nerr++; $display("FAIL first_miss_timeout got %0d want 0", obs_to); end
        nvec++; if (tx_addr.size() !== 1) begin nerr++; $display("FAIL first_miss_ntx got %0d want 1", tx_addr.size()); end
        else begin
            nvec++; if ({tx_rw[0], tx_addr[0]} !== {1'b0, 32'h0000_1000}) begin
                nerr++; $display("FAIL first_miss_req got rw=%0d addr=%h want rw=0 addr=00001000", tx_rw[0], tx_addr[0]); end
        end
        nvec++; if (obs_cyc !== 3 + obs_lat) begin nerr++; $display("FAIL clean_miss_latency got %0d want %0d", obs_cyc, 3 + obs_lat); end
        nvec++; if (obs_rdata !== 32'h1111_1111) begin nerr++; $display("FAIL first_miss_data got %h want 11111111", obs_rdata); end
    endtask

    task automatic test_fill();
        for (int k = 0; k < 2; k++) begin
            model(32'h0000_1004, 32'h0, 1'b0);
            access(32'h0000_1004, 32'h0, 1'b0);
            nvec++; if (obs_rdata !== 32'h2222_2222) begin nerr++; $display("FAIL fill_read%0d got %h want 22222222", k, obs_rdata); end
            nvec++; if (obs_cyc !== 1 || tx_addr.size() !== 0) begin
                nerr++; $display("FAIL hit_latency%0d got cyc=%0d ntx=%0d want 1/0", k, obs_cyc, tx_addr.size()); end
        end
    endtask

    task automatic test_write_hit();
        logic [31:0] ra [4] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
        logic [31:0] rd [4] = '{32'h1111_1111, 32'h2222_2222, 32'hDEAD_BEEF, 32'h4444_4444};
        cache_tag_type et = '{valid: 1'b1, dirty: 1'b1, tag: 18'h0};
        model(32'h0000_1008, 32'hDEAD_BEEF, 1'b1);
        access(32'h0000_1008, 32'hDEAD_BEEF, 1'b1);
        nvec++; if (obs_cyc !== 1 || tx_addr.size() !== 0) begin
            nerr++; $display("FAIL write_hit_latency got cyc=%0d ntx=%0d want 1/0", obs_cyc, tx_addr.size()); end
        nvec++; if (u_tag.lines[10'h100] !== et) begin nerr++; $display("FAIL write_hit_tag got %h want %h", u_tag.lines[10'h100], et); end
        for (int i = 0; i < 4; i++) begin
            model(ra[i], 32'h0, 1'b0);
            access(ra[i], 32'h0, 1'b0);
            nvec++; if (obs_rdata !== rd[i]) begin nerr++; $display("FAIL write_hit_readback a=%h got %h want %h", ra[i], obs_rdata, rd[i]); end
        end
    endtask

    task automatic test_conflict();
        logic [127:0] victim = {32'h4444_4444, 32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111};
        model(32'h0004_1000, 32'h0, 1'b0);
        access(32'h0004_1000, 32'h0, 1'b0);
        nvec++; if (tx_addr.size() !== 2) begin nerr++; $display("FAIL conflict_ntx got %0d want 2", tx_addr.size()); end
        else begin
            nvec++; if ({tx_rw[0], tx_addr[0]} !== {1'b1, 32'h0000_1000}) begin
                nerr++; $display("FAIL conflict_wb_req got rw=%0d addr=%h want rw=1 addr=00001000", tx_rw[0], tx_addr[0]); end
            nvec++; if (tx_data[0] !== victim) begin nerr++; $display("FAIL conflict_wb_data got %h want %h", tx_data[0], victim); end
            nvec++; if ({tx_rw[1], tx_addr[1]} !== {1'b0, 32'h0004_1000}) begin
                nerr++; $display("FAIL conflict_fill_req got rw=%0d addr=%h want rw=0 addr=00041000", tx_rw[1], tx_addr[1]); end
        end
        nvec++; if (obs_cyc !== 4 + obs_lat) begin nerr++; $display("FAIL dirty_miss_latency got %0d want %0d", obs_cyc, 4 + obs_lat); end
        nvec++; if (obs_rdata !== e_rdata) begin nerr++; $display("FAIL conflict_data got %h want %h", obs_rdata, e_rdata); end
    endtask

    task automatic test_write_miss();
        cache_tag_type et = '{valid: 1'b1, dirty: 1'b1, tag: 18'h20};
        model(32'h0008_2000, 32'hCAFE_F00D, 1'b1);
        access(32'h0008_2000, 32'hCAFE_F00D, 1'b1);
        nvec++; if (tx_addr.size() !== 1) begin nerr++; $display("FAIL write_miss_ntx got %0d want 1", tx_addr.size()); end
        else begin
            nvec++; if ({tx_rw[0], tx_addr[0]} !== {1'b0, 32'h0008_2000}) begin
                nerr++; $display("FAIL write_miss_req got rw=%0d addr=%h want rw=0 addr=00082000", tx_rw[0], tx_addr[0]); end
        end
        nvec++; if (obs_cyc !== 3 + obs_lat) begin nerr++; $display("FAIL write_miss_latency got %0d want %0d", obs_cyc, 3 + obs_lat); end
        nvec++; if (u_tag.lines[10'h200] !== et) begin nerr++; $display("FAIL write_miss_tag got %h want %h", u_tag.lines[10'h200], et); end
        model(32'h0008_2000, 32'h0, 1'b0);
        access(32'h0008_2000, 32'h0, 1'b0);
        nvec++; if (obs_rdata !== 32'hCAFE_F00D) begin nerr++; $display("FAIL write_miss_merge got %h want cafef00d", obs_rdata); end
        model(32'h0008_2004, 32'h0, 1'b0);
        access(32'h0008_2004, 32'h0, 1'b0);
        nvec++; if (obs_rdata !== e_rdata) begin nerr++; $display("FAIL write_miss_neighbour got %h want %h", obs_rdata, e_rdata); end
    endtask

    // Back-to-back random traffic over a few indices and tags so hits, clean and dirty misses mix.
    task automatic test_back_to_back();
        logic [9:0]  idxs [4] = '{10'h100, 10'h101, 10'h3FF, 10'h000};
        logic [17:0] tags [4] = '{18'h0, 18'h1, 18'h20, 18'h3FFFF};
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a = {tags[$urandom_range(0, 3)], idxs[$urandom_range(0, 3)], 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            logic [31:0] d = $urandom;
            bit          rw = 1'($urandom_range(0, 1));
            int          ecyc;
            model(a, d, rw);
            access(a, d, rw);
            ecyc = e_hit ? 1 : ((e_wb ? 4 : 3) + obs_lat);
            nvec++; if (obs_to !== 0 || obs_cyc !== ecyc) begin
                nerr++; $display("FAIL rand_latency n=%0d a=%h got %0d want %0d", n, a, obs_cyc, ecyc); end
            nvec++; if (tx_addr.size() !== e_ntx) begin
                nerr++; $display("FAIL rand_ntx n=%0d a=%h got %0d want %0d", n, a, tx_addr.size(), e_ntx); end
            else if (e_ntx > 0) begin
                if (e_wb) begin
                    nvec++; if ({tx_rw[0], tx_addr[0], tx_data[0]} !== {1'b1, e_wb_addr, e_wb_data}) begin
                        nerr++; $display("FAIL rand_wb n=%0d got rw=%0d addr=%h data=%h want rw=1 addr=%h data=%h",
                                         n, tx_rw[0], tx_addr[0], tx_data[0], e_wb_addr, e_wb_data); end
                end
                nvec++; if ({tx_rw[e_ntx-1], tx_addr[e_ntx-1]} !== {1'b0, e_rd_addr}) begin
                    nerr++; $display("FAIL rand_fill n=%0d got rw=%0d addr=%h want rw=0 addr=%h", n, tx_rw[e_ntx-1], tx_addr[e_ntx-1], e_rd_addr); end
            end
            if (!rw) begin
                nvec++; if (obs_rdata !== e_rdata) begin nerr++; $display("FAIL rand_read n=%0d a=%h got %h want %h", n, a, obs_rdata, e_rdata); end
            end
            nvec++; if (obs_bad0 !== 0) begin nerr++; $display("FAIL rand_idle_data n=%0d got %0d want 0", n, obs_bad0); end
        end
    endtask

    task automatic test_reset_mid_wb();
        int nwe, nidx, nbad;
        bit found = 0;
        model(32'h0000_3000, 32'h1234_5678, 1'b1);
        access(32'h0000_3000, 32'h1234_5678, 1'b1);
        cpu_req = '{addr: 32'h0010_3000, data: 32'h0, rw: 1'b0, valid: 1'b1};
        for (int c = 0; c < 20 && !found; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (mem_req.valid && mem_req.rw) found = 1;
        end
        nvec++; if (found !== 1) begin nerr++; $display("FAIL midwb_reached got %0d want 1", found); end
        rst = 1'b1;
        #1;
        nvec++; if ({mem_req.valid, tag_req.we, data_req.we, cpu_res.ready} !== 4'b0) begin
            nerr++; $display("FAIL midwb_reset_outputs got %b want 0000", {mem_req.valid, tag_req.we, data_req.we, cpu_res.ready}); end
        for (int c = 0; c < 3; c++) begin @(negedge clk); mem_data.ready = ~mem_data.ready; end
        @(negedge clk); rst = 1'b0;
        run_init(nwe, nidx, nbad, 1'b1);
        nvec++; if (nwe !== 1024 || nidx !== 0 || nbad !== 0) begin
            nerr++; $display("FAIL midwb_reinit got we=%0d idxerr=%0d bad=%0d want 1024/0/0", nwe, nidx, nbad); end
        model_reset();
        model(32'h0000_3000, 32'h0, 1'b0);
        access(32'h0000_3000, 32'h0, 1'b0);
        nvec++; if (obs_rdata !== e_rdata) begin nerr++; $display("FAIL midwb_lost_line got %h want %h", obs_rdata, e_rdata); end
        nvec++; if (tx_addr.size() !== 1) begin nerr++; $display("FAIL midwb_refill_ntx got %0d want 1", tx_addr.size()); end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired nvec=%0d", nvec);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fill();
        test_write_hit();
        test_conflict();
        test_write_miss();
        test_back_to_back();
        test_reset_mid_wb();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
